// File: rtl/pwm_duty_seq_pkg.sv
// Shared types and default sizing for the PWM duty sequencer.
package pwm_duty_seq_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_CHNL_NUM   = 4;
   localparam int DEF_DEPTH      = 8;
   localparam int RPT_WIDTH      = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_RUN  = 2'd2
   } seqState_t;

endpackage

// File: rtl/pwm_duty_seq_buf.sv
// Circular buffer of duty entries with push, pop and a head-relative read port.
module pwm_duty_seq_buf
   import pwm_duty_seq_pkg::*;
#(
   parameter int ENTRY_WIDTH = DEF_DATA_WIDTH * DEF_CHNL_NUM,
   parameter int DEPTH       = DEF_DEPTH
)
(
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_clr,
   input  logic                       i_push,
   input  logic [ENTRY_WIDTH-1:0]     i_pushData,
   input  logic                       i_pop,
   input  logic [$clog2(DEPTH)-1:0]   i_rdIdx,
   output logic [ENTRY_WIDTH-1:0]     o_rdData,
   output logic [$clog2(DEPTH):0]     o_cnt,
   output logic                       o_full
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = 1;
   localparam logic [AW-1:0] PTR_ONE  = 1;

   logic [ENTRY_WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]          r_wrPtr;
   logic [AW-1:0]          r_rdPtr;
   logic [AW:0]            r_cnt;
   logic [AW-1:0]          w_rdAddr;
   logic                   w_doPush;
   logic                   w_doPop;

   assign w_doPush = i_push && !i_clr && (r_cnt != FULL_CNT);
   assign w_doPop  = i_pop && !i_clr && (r_cnt != '0);
   assign w_rdAddr = r_rdPtr + i_rdIdx;
   assign o_rdData = r_mem[w_rdAddr];
   assign o_cnt    = r_cnt;
   assign o_full   = (r_cnt == FULL_CNT);

   // Entry storage needs no reset; the count alone decides what is valid.
   always_ff @(posedge i_clk) begin
      if (w_doPush) begin
         r_mem[r_wrPtr] <= i_pushData;
      end
   end

   // Pointers wrap naturally because the depth is a power of two; the count
   // tracks push/pop so a simultaneous push and pop leaves it unchanged.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_cnt   <= '0;
      end else if (i_clr) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_cnt   <= '0;
      end else begin
         if (w_doPush) begin
            r_wrPtr <= r_wrPtr + PTR_ONE;
         end
         if (w_doPop) begin
            r_rdPtr <= r_rdPtr + PTR_ONE;
         end
         if (w_doPush && !w_doPop) begin
            r_cnt <= r_cnt + CNT_ONE;
         end else if (w_doPop && !w_doPush) begin
            r_cnt <= r_cnt - CNT_ONE;
         end
      end
   end

endmodule

// File: rtl/pwm_duty_seq.sv
// PWM duty sequencer: feeds buffered compare-value entries into cr_o at
// PWM period boundaries, either consuming them (stream) or replaying them (loop).
module pwm_duty_seq
   import pwm_duty_seq_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int CHNL_NUM   = DEF_CHNL_NUM,
   parameter int DEPTH      = DEF_DEPTH
)
(
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           en_i,
   input  logic                           loop_i,
   input  logic                           clr_i,
   input  logic [RPT_WIDTH-1:0]           rpt_i,
   input  logic                           period_i,
   input  logic                           wr_valid_i,
   output logic                           wr_ready_o,
   input  logic [CHNL_NUM*DATA_WIDTH-1:0] wr_data_i,
   output logic [CHNL_NUM*DATA_WIDTH-1:0] cr_o,
   output logic                           cr_upd_o,
   output logic                           busy_o,
   output logic [$clog2(DEPTH):0]         cnt_o,
   output logic                           udf_o
);

   localparam int EW = CHNL_NUM * DATA_WIDTH;
   localparam int AW = $clog2(DEPTH);

   seqState_t              r_state;
   seqState_t              w_nextState;
   logic [EW-1:0]          r_cr;
   logic                   r_crUpd;
   logic [RPT_WIDTH-1:0]   r_rptCnt;
   logic [AW-1:0]          r_loopIdx;
   logic                   r_udf;

   logic                   w_load;
   logic                   w_decRpt;
   logic                   w_setUdf;
   logic                   w_avail;
   logic                   w_push;
   logic                   w_pop;
   logic                   w_wrReady;
   logic                   w_bufFull;
   logic [AW:0]            w_bufCnt;
   logic [AW-1:0]          w_rdIdx;
   logic [EW-1:0]          w_rdData;
   logic [AW:0]            w_idxInc;
   logic [AW-1:0]          w_idxNext;

   assign busy_o     = (r_state != ST_IDLE);
   assign w_wrReady  = !w_bufFull && !(loop_i && busy_o);
   assign wr_ready_o = w_wrReady;
   assign w_push     = wr_valid_i && w_wrReady && !clr_i;
   assign w_pop      = w_load && !loop_i;
   assign w_avail    = (w_bufCnt != '0);
   assign w_rdIdx    = loop_i ? r_loopIdx : '0;
   assign w_idxInc   = {1'b0, r_loopIdx} + {{AW{1'b0}}, 1'b1};
   assign w_idxNext  = (w_idxInc >= w_bufCnt) ? '0 : w_idxInc[AW-1:0];
   assign cr_o       = r_cr;
   assign cr_upd_o   = r_crUpd;
   assign cnt_o      = w_bufCnt;
   assign udf_o      = r_udf;

   pwm_duty_seq_buf #(
      .ENTRY_WIDTH (EW),
      .DEPTH       (DEPTH)
   ) u_buf (
      .i_clk      (clk_i),
      .i_rst      (rst_i),
      .i_clr      (clr_i),
      .i_push     (w_push),
      .i_pushData (wr_data_i),
      .i_pop      (w_pop),
      .i_rdIdx    (w_rdIdx),
      .o_rdData   (w_rdData),
      .o_cnt      (w_bufCnt),
      .o_full     (w_bufFull)
   );

   // Sequencer state register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state and per-period decisions; flush and disable override all
   // activity, and a buffer that is empty at the start of the cycle is never
   // loadable even if a write lands in that same cycle.
   always_comb begin
      w_nextState = r_state;
      w_load      = 1'b0;
      w_decRpt    = 1'b0;
      w_setUdf    = 1'b0;
      if (clr_i || !en_i) begin
         w_nextState = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_nextState = ST_ARM;
            end
            ST_ARM: begin
               if (period_i && w_avail) begin
                  w_load      = 1'b1;
                  w_nextState = ST_RUN;
               end
            end
            ST_RUN: begin
               if (period_i) begin
                  if (r_rptCnt != '0) begin
                     w_decRpt = 1'b1;
                  end else if (w_avail) begin
                     w_load = 1'b1;
                  end else begin
                     w_setUdf = 1'b1;
                  end
               end
            end
            default: begin
               w_nextState = ST_IDLE;
            end
         endcase
      end
   end

   // Compare register, update pulse, repeat counter, loop index and sticky
   // underflow; the compare value survives flush and disable, only reset clears it.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_cr      <= '0;
         r_crUpd   <= 1'b0;
         r_rptCnt  <= '0;
         r_loopIdx <= '0;
         r_udf     <= 1'b0;
      end else begin
         r_crUpd <= w_load;
         if (w_load) begin
            r_cr <= w_rdData;
         end
         if (clr_i) begin
            r_rptCnt <= '0;
            r_udf    <= 1'b0;
         end else begin
            if (w_load) begin
               r_rptCnt <= rpt_i;
            end else if (w_decRpt) begin
               r_rptCnt <= r_rptCnt - {{(RPT_WIDTH-1){1'b0}}, 1'b1};
            end
            if (w_setUdf) begin
               r_udf <= 1'b1;
            end
         end
         if (w_nextState == ST_IDLE) begin
            r_loopIdx <= '0;
         end else if (w_load && loop_i) begin
            r_loopIdx <= w_idxNext;
         end
      end
   end

endmodule

// File: tb/tb_pwm_duty_seq.sv
// Self-checking bench for pwm_duty_seq: a constant-expectation table for the
// stream scenario, hand-written multi-cycle sequences, and randomized traffic
// compared every cycle against a queue-based reference model.
module tb_pwm_duty_seq;

   localparam int DW    = 32;
   localparam int CN    = 4;
   localparam int DEPTH = 8;
   localparam int EW    = DW * CN;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          loopMode;
   logic          clr;
   logic [7:0]    rpt;
   logic          period;
   logic          wrValid;
   logic          wrReady;
   logic [EW-1:0] wrData;
   logic [EW-1:0] cr;
   logic          crUpd;
   logic          busy;
   logic [3:0]    cnt;
   logic          udf;

   int vectors     = 0;
   int miscompares = 0;

   logic [EW-1:0] mQ[$];
   int            mState;
   logic [EW-1:0] mCr;
   bit            mUpd;
   int            mRpt;
   int            mIdx;
   bit            mUdf;

   bit            curLoop;
   logic [7:0]    curRpt;

   typedef struct {
      bit            en;
      bit            per;
      bit            wv;
      logic [EW-1:0] data;
      logic [EW-1:0] expCr;
      bit            expUpd;
      int            expCnt;
      bit            expBusy;
      bit            expUdf;
      bit            expReady;
   } vec_t;

   vec_t tbl[13];

   pwm_duty_seq #(
      .DATA_WIDTH (DW),
      .CHNL_NUM   (CN),
      .DEPTH      (DEPTH)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .en_i       (en),
      .loop_i     (loopMode),
      .clr_i      (clr),
      .rpt_i      (rpt),
      .period_i   (period),
      .wr_valid_i (wrValid),
      .wr_ready_o (wrReady),
      .wr_data_i  (wrData),
      .cr_o       (cr),
      .cr_upd_o   (crUpd),
      .busy_o     (busy),
      .cnt_o      (cnt),
      .udf_o      (udf)
   );

   always #5 clk = ~clk;

   function automatic logic [EW-1:0] mkEntry(input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] c, input logic [31:0] d);
      return {d, c, b, a};
   endfunction

   function automatic vec_t mkVec(input bit e, input bit p, input bit wv, input logic [EW-1:0] d,
                                  input logic [EW-1:0] xCr, input bit xUpd, input int xCnt,
                                  input bit xBusy, input bit xUdf, input bit xRdy);
      vec_t v;
      v.en = e; v.per = p; v.wv = wv; v.data = d;
      v.expCr = xCr; v.expUpd = xUpd; v.expCnt = xCnt;
      v.expBusy = xBusy; v.expUdf = xUdf; v.expReady = xRdy;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic expectNow(input string tag, input logic [EW-1:0] xCr, input bit xUpd, input int xCnt,
                            input bit xBusy, input bit xUdf, input bit xRdy);
      checkOutput({tag, " cr"},    cr,             xCr);
      checkOutput({tag, " upd"},   EW'(crUpd),     EW'(xUpd));
      checkOutput({tag, " cnt"},   EW'(cnt),       EW'(xCnt));
      checkOutput({tag, " busy"},  EW'(busy),      EW'(xBusy));
      checkOutput({tag, " udf"},   EW'(udf),       EW'(xUdf));
      checkOutput({tag, " ready"}, EW'(wrReady),   EW'(xRdy));
   endtask

   task automatic modelReset();
      mQ.delete();
      mState = 0; mCr = '0; mUpd = 0; mRpt = 0; mIdx = 0; mUdf = 0;
   endtask

   // Reference: entries are a queue; stream pops the front, loop indexes it.
   task automatic modelStep();
      int sizePre;
      bit readyPre;
      bit avail;
      bit doLoad;
      sizePre  = mQ.size();
      readyPre = (sizePre < DEPTH) && !(loopMode && mState != 0);
      avail    = (sizePre > 0);
      doLoad   = 0;
      mUpd     = 0;
      if (clr) begin
         mQ.delete();
         mRpt = 0; mIdx = 0; mUdf = 0; mState = 0;
      end else begin
         if (!en) begin
            mState = 0;
            mIdx   = 0;
         end else if (mState == 0) begin
            mState = 1;
         end else if (period) begin
            if (mState == 2 && mRpt > 0) mRpt--;
            else if (avail) doLoad = 1;
            else if (mState == 2) mUdf = 1;
         end
         if (doLoad) begin
            if (loopMode) begin
               mCr  = mQ[mIdx];
               mIdx = (mIdx + 1 >= sizePre) ? 0 : mIdx + 1;
            end else begin
               mCr = mQ.pop_front();
            end
            mRpt   = int'(rpt);
            mUpd   = 1;
            mState = 2;
         end
         if (wrValid && readyPre) mQ.push_back(wrData);
      end
   endtask

   task automatic compareModel();
      expectNow("model", mCr, mUpd, mQ.size(), mState != 0, mUdf,
                (mQ.size() < DEPTH) && !(loopMode && mState != 0));
   endtask

   task automatic applyStimulus(input bit e, input bit lp, input bit c, input logic [7:0] r,
                                input bit p, input bit wv, input logic [EW-1:0] d);
      en = e; loopMode = lp; clr = c; rpt = r; period = p; wrValid = wv; wrData = d;
      @(posedge clk);
      #1;
      modelStep();
      compareModel();
   endtask

   task automatic step(input bit e, input bit p, input bit wv, input logic [EW-1:0] d);
      applyStimulus(e, curLoop, 1'b0, curRpt, p, wv, d);
   endtask

   task automatic clrStep(input bit e, input bit wv, input logic [EW-1:0] d);
      applyStimulus(e, curLoop, 1'b1, curRpt, 1'b0, wv, d);
   endtask

   initial begin
      logic [EW-1:0] e1, e2, a, b, x, y;
      logic [EW-1:0] lv[3];
      logic [EW-1:0] fv[10];

      rst = 1'b1; en = 0; loopMode = 0; clr = 0; rpt = '0; period = 0; wrValid = 0; wrData = '0;
      curLoop = 0; curRpt = 8'd0;
      modelReset();
      #12;
      rst = 1'b0;
      #1;
      expectNow("reset", '0, 0, 0, 0, 0, 1);

      // Stream table: two entries, three periods, underflow, then re-arm.
      e1 = mkEntry(10, 20, 30, 40);
      e2 = mkEntry(50, 60, 70, 80);
      tbl[0]  = mkVec(0, 0, 1, e1, '0, 0, 1, 0, 0, 1);
      tbl[1]  = mkVec(0, 0, 1, e2, '0, 0, 2, 0, 0, 1);
      tbl[2]  = mkVec(1, 0, 0, '0, '0, 0, 2, 1, 0, 1);
      tbl[3]  = mkVec(1, 1, 0, '0, e1, 1, 1, 1, 0, 1);
      tbl[4]  = mkVec(1, 0, 0, '0, e1, 0, 1, 1, 0, 1);
      tbl[5]  = mkVec(1, 1, 0, '0, e2, 1, 0, 1, 0, 1);
      tbl[6]  = mkVec(1, 0, 0, '0, e2, 0, 0, 1, 0, 1);
      tbl[7]  = mkVec(1, 1, 0, '0, e2, 0, 0, 1, 1, 1);
      tbl[8]  = mkVec(1, 0, 0, '0, e2, 0, 0, 1, 1, 1);
      tbl[9]  = mkVec(0, 1, 0, '0, e2, 0, 0, 0, 1, 1);
      tbl[10] = mkVec(1, 1, 0, '0, e2, 0, 0, 1, 1, 1);
      tbl[11] = mkVec(1, 1, 1, e1, e2, 0, 1, 1, 1, 1);
      tbl[12] = mkVec(1, 1, 0, '0, e1, 1, 0, 1, 1, 1);
      for (int i = 0; i < 13; i++) begin
         step(tbl[i].en, tbl[i].per, tbl[i].wv, tbl[i].data);
         expectNow($sformatf("tbl%0d", i), tbl[i].expCr, tbl[i].expUpd, tbl[i].expCnt,
                   tbl[i].expBusy, tbl[i].expUdf, tbl[i].expReady);
      end

      // Repeat: A held for three periods, B loaded on the fourth.
      curRpt = 8'd2;
      a = mkEntry(1, 2, 3, 4);
      b = mkEntry(5, 6, 7, 8);
      clrStep(0, 0, '0);
      expectNow("rpt clr", e1, 0, 0, 0, 0, 1);
      step(0, 0, 1, a);
      step(1, 0, 0, '0);
      step(1, 1, 0, '0);
      expectNow("rpt p1", a, 1, 0, 1, 0, 1);
      step(1, 0, 1, b);
      step(1, 1, 0, '0);
      expectNow("rpt p2", a, 0, 1, 1, 0, 1);
      step(1, 1, 0, '0);
      expectNow("rpt p3", a, 0, 1, 1, 0, 1);
      step(1, 1, 0, '0);
      expectNow("rpt p4", b, 1, 0, 1, 0, 1);

      // Loop: three entries replayed 0,1,2,0,1,2,0 with writes refused.
      curRpt  = 8'd0;
      curLoop = 1;
      clrStep(0, 0, '0);
      for (int i = 0; i < 3; i++) begin
         lv[i] = mkEntry(200 + i, 300 + i, 400 + i, 500 + i);
         step(0, 0, 1, lv[i]);
      end
      step(1, 0, 0, '0);
      expectNow("loop arm", b, 0, 3, 1, 0, 0);
      for (int k = 0; k < 7; k++) begin
         step(1, 1, 1, mkEntry(9, 9, 9, 9));
         expectNow($sformatf("loop p%0d", k), lv[k % 3], 1, 3, 1, 0, 0);
         step(1, 0, 0, '0);
      end
      step(0, 0, 0, '0);

      // Full buffer and back-pressure.
      curLoop = 0;
      clrStep(0, 0, '0);
      for (int i = 0; i < 10; i++) fv[i] = mkEntry(100 + i, 110 + i, 120 + i, 130 + i);
      for (int i = 0; i < 8; i++) begin
         step(0, 0, 1, fv[i]);
         expectNow($sformatf("fill%0d", i), lv[0], 0, i + 1, 0, 0, i < 7);
      end
      step(0, 0, 1, fv[8]);
      expectNow("full rej", lv[0], 0, 8, 0, 0, 0);
      step(1, 0, 0, '0);
      step(1, 1, 0, '0);
      expectNow("full ld0", fv[0], 1, 7, 1, 0, 1);
      step(1, 0, 1, fv[8]);
      expectNow("full refill", fv[0], 0, 8, 1, 0, 0);
      step(1, 1, 1, fv[9]);
      expectNow("full pop", fv[1], 1, 7, 1, 0, 1);
      step(1, 1, 1, fv[9]);
      expectNow("pushpop", fv[2], 1, 7, 1, 0, 1);

      // Flush with underflow and five buffered entries.
      clrStep(0, 0, '0);
      x = mkEntry(7, 7, 7, 7);
      step(0, 0, 1, x);
      step(1, 0, 0, '0);
      step(1, 1, 0, '0);
      step(1, 1, 0, '0);
      expectNow("udf set", x, 0, 0, 1, 1, 1);
      for (int i = 0; i < 5; i++) step(1, 0, 1, fv[i]);
      expectNow("pre clr", x, 0, 5, 1, 1, 1);
      clrStep(1, 1, fv[5]);
      expectNow("post clr", x, 0, 0, 0, 0, 1);

      // Asynchronous reset mid-run.
      y = mkEntry(33, 44, 55, 66);
      step(0, 0, 1, y);
      step(1, 0, 0, '0);
      step(1, 1, 0, '0);
      expectNow("pre rst", y, 1, 0, 1, 0, 1);
      #3;
      rst = 1'b1;
      #1;
      checkOutput("async rst cr",   cr,         '0);
      checkOutput("async rst busy", EW'(busy),  '0);
      modelReset();
      #2;
      rst = 1'b0;
      step(0, 0, 0, '0);
      expectNow("post rst", '0, 0, 0, 0, 0, 1);

      // Randomized segments, each starting from a flush with a fixed mode.
      for (int s = 0; s < 6; s++) begin
         curLoop = bit'($urandom_range(0, 1));
         clrStep(0, 0, '0);
         for (int c = 0; c < 120; c++) begin
            logic [7:0] r;
            r = ($urandom_range(0, 31) == 0) ? 8'd255 : 8'($urandom_range(0, 2));
            applyStimulus($urandom_range(0, 15) != 0, curLoop, $urandom_range(0, 63) == 0, r,
                          $urandom_range(0, 3) == 0, bit'($urandom_range(0, 1)),
                          {$urandom(), $urandom(), $urandom(), $urandom()});
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
